// File: rtl/pu_msp430_per_master_pkg.sv
// ----------------------------------------------------------------------------
// pu_msp430_per_master_pkg
// Shared types and constants for the MSP430 peripheral-bus initiator.
//   per_master_state_t : controller state (IDLE/WRITE/READ/DRAIN)
//   PER_AW / PER_DW    : peripheral bus word-address and data widths
// ----------------------------------------------------------------------------
package pu_msp430_per_master_pkg;

  localparam int PER_AW = 14;
  localparam int PER_DW = 16;

  // Address increment constant, sized to the bus so additions wrap cleanly.
  localparam logic [PER_AW-1:0] ADDR_ONE = {{(PER_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } per_master_state_t;

endpackage : pu_msp430_per_master_pkg

// File: rtl/pu_msp430_per_master.sv
// ----------------------------------------------------------------------------
// pu_msp430_per_master
// Peripheral-bus initiator: converts a command stream into MSP430 16-bit
// peripheral bus cycles, single or auto-incrementing burst.
//
// Ports
//   mclk, puc_rst_n       : clock, synchronous active-low reset
//   cmd_valid/ready       : command handshake (ready only in IDLE)
//   cmd_addr/we/len       : start word address, byte mask (0 = read), words-1
//   wd_valid/ready/data   : write-data stream, one beat = one bus cycle
//   rd_valid/ready/data   : read-data stream from a one-entry output slot
//   rd_last               : marks the final beat of a read burst
//   done                  : one-cycle completion pulse
//   busy                  : controller not in IDLE
//   per_en/we/addr/din    : peripheral bus request
//   per_dout              : peripheral read data, valid in the per_en cycle
// ----------------------------------------------------------------------------
module pu_msp430_per_master
  import pu_msp430_per_master_pkg::*;
#(
  parameter int LEN_WD = 4
) (
  input  logic                mclk,
  input  logic                puc_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PER_AW-1:0]   cmd_addr,
  input  logic [1:0]          cmd_we,
  input  logic [LEN_WD-1:0]   cmd_len,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [PER_DW-1:0]   wd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [PER_DW-1:0]   rd_data,
  output logic                rd_last,
  output logic                done,
  output logic                busy,
  output logic                per_en,
  output logic [1:0]          per_we,
  output logic [PER_AW-1:0]   per_addr,
  output logic [PER_DW-1:0]   per_din,
  input  logic [PER_DW-1:0]   per_dout
);

  localparam logic [LEN_WD-1:0] LEN_ONE = {{(LEN_WD-1){1'b0}}, 1'b1};

  per_master_state_t   state_q,     state_d;
  logic [PER_AW-1:0]   addr_q,      addr_d;
  logic [1:0]          we_q,        we_d;
  logic [LEN_WD-1:0]   remaining_q, remaining_d;
  logic                rd_valid_q,  rd_valid_d;
  logic [PER_DW-1:0]   rd_data_q,   rd_data_d;
  logic                rd_last_q,   rd_last_d;
  logic                done_q,      done_d;
  logic                cmd_ready_q, cmd_ready_d;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    remaining_d = remaining_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    rd_last_d   = rd_last_q;
    done_d      = 1'b0;
    wd_ready    = 1'b0;
    per_en      = 1'b0;
    per_we      = 2'b00;
    per_addr    = '0;
    per_din     = '0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          we_d        = cmd_we;
          remaining_d = cmd_len;
          state_d     = (cmd_we != 2'b00) ? WRITE : READ;
        end
      end

      WRITE: begin
        wd_ready = 1'b1;
        // A cycle without wd_valid is simply a bubble on the bus.
        if (wd_valid) begin
          per_en      = 1'b1;
          per_we      = we_q;
          per_addr    = addr_q;
          per_din     = wd_data;
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      READ: begin
        // Issue only when the output slot is empty or being emptied now,
        // so held read data is never overwritten.
        if (!rd_valid_q || rd_ready) begin
          per_en      = 1'b1;
          per_addr    = addr_q;
          rd_valid_d  = 1'b1;
          rd_data_d   = per_dout;
          rd_last_d   = (remaining_q == '0);
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == '0) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered so it stays low through reset and rises on the first edge
    // after reset is released.
    cmd_ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 2'b00;
      remaining_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      remaining_q <= remaining_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule : pu_msp430_per_master

// File: tb/tb_pu_msp430_per_master.sv
// ----------------------------------------------------------------------------
// tb_pu_msp430_per_master
// Self-checking bench for the peripheral-bus initiator. A four-register
// 16-bit peripheral (cntrl1..cntrl4 at word addresses 00C8..00CB) sits on
// the bus. Inputs change on the falling edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_pu_msp430_per_master;

  logic        clk = 1'b0;
  logic        puc_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [13:0] cmd_addr;
  logic [1:0]  cmd_we;
  logic [3:0]  cmd_len;
  logic        wd_valid;
  logic        wd_ready;
  logic [15:0] wd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        busy;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;

  always #5 clk = ~clk;

  pu_msp430_per_master #(.LEN_WD(4)) dut (
    .mclk      (clk),
    .puc_rst_n (puc_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_we    (cmd_we),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .done      (done),
    .busy      (busy),
    .per_en    (per_en),
    .per_we    (per_we),
    .per_addr  (per_addr),
    .per_din   (per_din),
    .per_dout  (per_dout)
  );

  // Peripheral model: four byte-writable 16-bit registers at 00C8..00CB.
  logic [15:0] cntrl [4];
  wire         hit = (per_addr[13:2] == 12'h032);

  assign per_dout = (per_en && hit) ? cntrl[per_addr[1:0]] : 16'h0000;

  always @(posedge clk) begin
    if (per_en && hit) begin
      if (per_we[0]) cntrl[per_addr[1:0]][7:0]  <= per_din[7:0];
      if (per_we[1]) cntrl[per_addr[1:0]][15:8] <= per_din[15:8];
    end
  end

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"},
          {24'd0, cmd_ready, wd_ready, rd_valid, rd_last, done, busy, per_en, 1'b0},
          32'd0);
    check({name, "_rd_data"}, {16'd0, rd_data}, 32'd0);
    check({name, "_per_bus"}, {per_we, per_addr, per_din}, 32'd0);
  endtask

  // Presents a command and returns 1 ns after the accepting edge.
  task automatic issue_cmd(input logic [13:0] a, input logic [1:0] we, input logic [3:0] len);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_we = we; cmd_len = len;
    #1;
    while (!cmd_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [13:0] a, input logic [1:0] we, input logic [3:0] len,
                             input logic [15:0] d [4], input int bubble);
    int done_before = done_cnt;
    issue_cmd(a, we, len);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      if (i == bubble) begin
        wd_valid = 1'b0;
        #1;
        check("wr_bubble_en",  {31'd0, per_en}, 32'd0);
        check("wr_bubble_din", {16'd0, per_din}, 32'd0);
        @(negedge clk);
      end
      wd_valid = 1'b1; wd_data = d[i];
      #1;
      check("wr_wd_ready", {31'd0, wd_ready}, 32'd1);
      check("wr_per_en",   {31'd0, per_en}, 32'd1);
      check("wr_per_addr", {18'd0, per_addr}, {18'd0, 14'(a + 14'(i))});
      check("wr_per_we",   {30'd0, per_we}, {30'd0, we});
      check("wr_per_din",  {16'd0, per_din}, {16'd0, d[i]});
    end
    @(negedge clk);
    wd_valid = 1'b0; wd_data = 16'h0000;
    #1;
    check("wr_done",     {31'd0, done}, 32'd1);
    check("wr_busy",     {31'd0, busy}, 32'd0);
    check("wr_done_cnt", done_cnt, done_before + 1);
  endtask

  // Runs the read side after the command was accepted. pattern[k] is
  // rd_ready in loop cycle k (1 after the eighth cycle).
  task automatic read_body(input logic [3:0] len, input logic [7:0] pattern,
                           input logic [15:0] exp_data [4], input logic [13:0] exp_addr [4],
                           input int exp_done_cyc);
    int          issued = 0;
    int          acc    = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = 16'h0;
    bit          got_done   = 1'b0;
    for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
      @(negedge clk);
      rd_ready = (cyc < 8) ? pattern[cyc] : 1'b1;
      #1;
      if (done) begin
        check("rd_done_beats", acc, int'(len) + 1);
        if (exp_done_cyc >= 0) check("rd_done_cycle", cyc, exp_done_cyc);
        check("rd_valid_cleared", {31'd0, rd_valid}, 32'd0);
        got_done = 1'b1;
      end else begin
        if (prev_stall) begin
          check("rd_hold_valid", {31'd0, rd_valid}, 32'd1);
          check("rd_hold_data",  {16'd0, rd_data}, {16'd0, prev_data});
        end
        if (per_en) begin
          check("rd_per_addr", {18'd0, per_addr}, {18'd0, exp_addr[issued % 4]});
          check("rd_per_we",   {30'd0, per_we}, 32'd0);
          issued++;
        end
        if (rd_valid && rd_ready) begin
          check("rd_data", {16'd0, rd_data}, {16'd0, exp_data[acc % 4]});
          check("rd_last", {31'd0, rd_last}, {31'd0, acc == int'(len)});
          acc++;
        end
        prev_stall = rd_valid && !rd_ready;
        prev_data  = rd_data;
      end
    end
    if (!got_done) check("rd_done_timeout", 32'd0, 32'd1);
    rd_ready = 1'b0;
  endtask

  // Table of single-word writes and the register value expected on read-back.
  typedef struct {
    logic [13:0] addr;
    logic [1:0]  we;
    logic [15:0] wdata;
    logic [15:0] exp_reg;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [15:0] d    [4];
    logic [15:0] ed   [4];
    logic [13:0] ea   [4];
    int          db;

    vecs[0] = '{14'h00C8, 2'b11, 16'h1234, 16'h1234};
    vecs[1] = '{14'h00C8, 2'b01, 16'hABCD, 16'h12CD};
    vecs[2] = '{14'h00C8, 2'b10, 16'h5678, 16'h56CD};
    vecs[3] = '{14'h00CA, 2'b11, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{14'h00CA, 2'b10, 16'h0000, 16'h00FF};

    for (int i = 0; i < 4; i++) cntrl[i] = 16'h0000;
    puc_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_we = '0; cmd_len = '0;
    wd_valid  = 1'b0; wd_data = '0;
    rd_ready  = 1'b0;

    // Power-on reset state.
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("por");
    @(negedge clk);
    puc_rst_n = 1'b1;
    @(negedge clk); #1;
    check("por_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Single full-word write to cntrl2.
    d = '{16'hA5A5, 16'h0, 16'h0, 16'h0};
    write_burst(14'h00C9, 2'b11, 4'd0, d, -1);
    check("cntrl2_a5a5", {16'd0, cntrl[1]}, 32'h0000A5A5);

    // Four-word burst with one bubble before the third beat.
    d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    write_burst(14'h00C8, 2'b11, 4'd3, d, 2);
    check("cntrl4_4444", {16'd0, cntrl[3]}, 32'h00004444);

    // Burst read with rd_ready 1,0,1,1,0,1.
    ed = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    ea = '{14'h00C8, 14'h00C9, 14'h00CA, 14'h00CB};
    issue_cmd(14'h00C8, 2'b00, 4'd3);
    read_body(4'd3, 8'b1110_1101, ed, ea, -1);

    // Address wrap, no stalls: done at accept + L + 3.
    ed = '{16'h0, 16'h0, 16'h0, 16'h0};
    ea = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0000};
    issue_cmd(14'h3FFE, 2'b00, 4'd2);
    read_body(4'd2, 8'hFF, ed, ea, 4);

    // Byte write; a read command waits until the write completes.
    issue_cmd(14'h00C9, 2'b01, 4'd0);
    @(negedge clk);
    wd_valid = 1'b1; wd_data = 16'hBEEF;
    cmd_valid = 1'b1; cmd_we = 2'b00; cmd_addr = 14'h00C9; cmd_len = 4'd0;
    #1;
    check("byte_cmd_held", {31'd0, cmd_ready}, 32'd0);
    check("byte_per_we",   {30'd0, per_we}, 32'd1);
    check("byte_per_din",  {16'd0, per_din}, 32'h0000BEEF);
    @(negedge clk);
    wd_valid = 1'b0;
    #1;
    check("byte_done",      {31'd0, done}, 32'd1);
    check("byte_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ed = '{16'h22EF, 16'h0, 16'h0, 16'h0};
    ea = '{14'h00C9, 14'h0, 14'h0, 14'h0};
    read_body(4'd0, 8'hFF, ed, ea, 2);
    check("cntrl2_22ef", {16'd0, cntrl[1]}, 32'h000022EF);

    // Table-driven single writes with read-back.
    for (int v = 0; v < 5; v++) begin
      d  = '{vecs[v].wdata, 16'h0, 16'h0, 16'h0};
      write_burst(vecs[v].addr, vecs[v].we, 4'd0, d, -1);
      ed = '{vecs[v].exp_reg, 16'h0, 16'h0, 16'h0};
      ea = '{vecs[v].addr, 14'h0, 14'h0, 14'h0};
      issue_cmd(vecs[v].addr, 2'b00, 4'd0);
      read_body(4'd0, 8'hFF, ed, ea, 2);
    end

    // Reset during a stalled read burst: everything drops, no done.
    issue_cmd(14'h00C8, 2'b00, 4'd3);
    @(negedge clk);
    rd_ready = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rd_valid", {31'd0, rd_valid}, 32'd1);
    db = done_cnt;
    puc_rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check_all_zero("mid_rst");
    end
    puc_rst_n = 1'b1;
    rd_ready  = 1'b1;
    @(negedge clk); #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    check("rst_no_done",   done_cnt, db);
    check("rst_rd_valid",  {31'd0, rd_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pu_msp430_per_master

// File: doc/pu_msp430_per_master.md
# pu_msp430_per_master

Peripheral-bus initiator for the MSP430 16-bit peripheral interface. It turns a command stream into word-addressed peripheral bus cycles (`per_en`/`per_we`/`per_addr`/`per_din`) and returns read data from `per_dout`. It supports single and auto-incrementing burst accesses. It sits between a test/DMA-style requester and any peripheral slave on the bus, and gives non-CPU logic a path to peripheral registers.

## Interface
- `LEN_WD`, default 4: burst length field width; burst = `cmd_len`+1 words (1..16).
- `mclk` input 1: main system clock; all logic on rising edge.
- `puc_rst_n` input 1: reset, synchronous, active-low.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accepted when high with `cmd_valid`.
- `cmd_addr` input 14: start word address (peripheral bus address).
- `cmd_we` input 2: byte write mask driven on `per_we`; 2'b00 = read burst.
- `cmd_len` input LEN_WD: words minus one.
- `wd_valid` input 1: write-data beat available.
- `wd_ready` output 1: write-data beat consumed.
- `wd_data` input 16: write data.
- `rd_valid` output 1: read-data beat available.
- `rd_ready` input 1: read-data beat consumed.
- `rd_data` output 16: captured `per_dout`.
- `rd_last` output 1: final beat of a read burst.
- `done` output 1: one-cycle pulse after the last bus cycle of a write burst, or when the last read beat is accepted.
- `busy` output 1: high in any state other than IDLE.
- `per_en` output 1: peripheral enable.
- `per_we` output 2: peripheral write enable.
- `per_addr` output 14: peripheral address.
- `per_din` output 16: peripheral write data.
- `per_dout` input 16: peripheral read data, valid combinationally in the `per_en` cycle.

## Operation
**States:**
- IDLE, WRITE, READ, DRAIN.
- `cmd_ready` = 1 only in IDLE.

**Command acceptance**
- On a `cmd_valid && cmd_ready` handshake, latch `addr`, `we`, and `remaining` = `cmd_len`.
- Go to WRITE if `cmd_we` != 0, else READ.

**WRITE**
- `wd_ready` = 1 in WRITE only.
- Each `wd_valid` cycle is one bus cycle: `per_en` = 1, `per_we` = latched mask, `per_addr` = `addr`, `per_din` = `wd_data`. Signals are combinational from state and registers, so the beat and the bus cycle happen in the same clock.
- No `wd_valid` → `per_en` = 0 that cycle; this is a bubble, not an error.
- After each beat, `addr` += 1; the address wraps 14'h3FFF → 14'h0000.
- On the beat with `remaining` = 0: pulse `done` the next cycle and return to IDLE.

**READ**
- Issue a bus cycle (`per_en` = 1, `per_we` = 0) when the output slot is free: `!rd_valid || rd_ready`.
- At that edge, capture `per_dout` into `rd_data` and set `rd_valid`.
- `rd_last` = 1 for the beat captured when `remaining` = 0.
- After each beat, `addr` += 1 (same wrap) and `remaining` -= 1.
- After the last issue, go to DRAIN.

**DRAIN**
- Hold `rd_valid`/`rd_data`/`rd_last` until `rd_ready`.
- Then pulse `done`, clear `rd_valid`, and go to IDLE.

**Output rules**
- `per_din` = 0 and `per_we` = 0 whenever `per_en` = 0.
- `per_we` is always 0 in READ.
- `rd_valid` and `rd_data` are stable while `rd_valid && !rd_ready`.

**Reset**
- While `puc_rst_n` is low at a clock edge, all outputs go to 0 and the state goes to IDLE.
- This applies mid-burst: remaining beats are dropped, no `done` is issued, and held read data is discarded.
- `cmd_ready` rises the first cycle after reset deasserts.

## Timing
- Write throughput: 1 word/cycle with continuous `wd_valid`.
- Write command latency: `cmd_valid` accepted in cycle N; the first bus cycle can occur no earlier than N+1.
- Read throughput: 1 word/cycle with `rd_ready` held high.
- Read latency: bus cycle at N, `rd_valid` at N+1.
- Burst of L+1 words with no stalls: WRITE `done` at accept+L+2; READ `done` at accept+L+3. Here `done` means the cycle in which the pulse is high.
- Back-to-back commands: a new command can be accepted the cycle `done` is high (the state is IDLE).

## Structure
- Shared package `pu_msp430_per_master_pkg`:
  - state enum type `per_master_state_t` (IDLE/WRITE/READ/DRAIN);
  - `PER_AW` = 14;
  - `PER_DW` = 16.
- Single module, no sub-module. The read output slot is a one-entry register inside the module.

## Test plan
1. Reset held low 3 cycles mid-READ burst → all outputs 0; IDLE with `cmd_ready` = 1 one cycle after release; no `done`.
2. Single write to a template16 peripheral: `cmd_addr` = 14'h00C9, `cmd_we` = 2'b11, `cmd_len` = 0, `wd_data` = 16'hA5A5 → one cycle with `per_en` = 1, `per_addr` = 00C9, `per_din` = A5A5; `cntrl2_16b` = 16'hA5A5; one `done` pulse.
3. Burst write, `cmd_addr` = 14'h00C8, `cmd_len` = 3, data 1111/2222/3333/4444 with `wd_valid` low for one cycle after beat 2 → addresses 00C8..00CB; one bubble with `per_en` = 0; `cntrl4_16b` = 16'h4444.
4. Burst read of the same four registers with `rd_ready` toggling 1,0,1,1,0,1 → `rd_data` 1111,2222,3333,4444 in order; data held during stalls; `rd_last` on 4444 only; `done` after the final accept.
5. Wrap: read `cmd_addr` = 14'h3FFE, `cmd_len` = 2 → `per_addr` 3FFE, 3FFF, 0000.
6. Byte write `cmd_we` = 2'b01 → `per_we` = 01 on the bus cycle; a read command presented during WRITE is held off (`cmd_ready` = 0) until `done`.
